// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register for the 5-stage MIPS core.
// Holds one instruction slot (valid, payload, destination register, Tnew).
// It supports stall (hold), flush (bubble insertion) and optional Tnew ageing
// while stalled. It also keeps saturating stall/bubble counters for
// hazard-unit debug.
// Update priority on each edge is reset > flush > stall > advance.
module pipe_stage_reg #(
    parameter int PAYLOAD_W    = 96,
    parameter int REG_AW       = 5,
    parameter int TNEW_W       = 2,
    parameter int AGE_ON_STALL = 0,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [REG_AW-1:0]    in_a3,
    input  logic [TNEW_W-1:0]    in_tnew,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [REG_AW-1:0]    out_a3,
    output logic [TNEW_W-1:0]    out_tnew,
    output logic                 fwd_hit,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                 valid_q,      valid_d;
    logic [PAYLOAD_W-1:0] payload_q,    payload_d;
    logic [REG_AW-1:0]    a3_q,         a3_d;
    logic [TNEW_W-1:0]    tnew_q,       tnew_d;
    logic [CNT_W-1:0]     stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0]     bubble_cnt_q, bubble_cnt_d;

    logic stall_evt;
    logic bubble_evt;

    // A flush that coincides with a stall counts only as a bubble.
    // An upstream bubble is counted only when the stage actually advances.
    assign stall_evt  = stall & ~flush;
    assign bubble_evt = flush | (~stall & ~in_valid);

    // Next-state selection for the instruction slot.
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        a3_d      = a3_q;
        tnew_d    = tnew_q;
        if (flush) begin
            valid_d   = 1'b0;
            payload_d = '0;
            a3_d      = '0;
            tnew_d    = '0;
        end else if (stall) begin
            // The held instruction keeps progressing towards its result while
            // it sits here. Tnew therefore ages, floored at zero.
            if ((AGE_ON_STALL != 0) && (tnew_q != '0)) begin
                tnew_d = tnew_q - TNEW_W'(1);
            end
        end else if (in_valid) begin
            valid_d   = 1'b1;
            payload_d = in_payload;
            a3_d      = in_a3;
            tnew_d    = in_tnew;
        end else begin
            // Bubbles carry a3=0, so a bubble can never produce a forwarding hit.
            valid_d   = 1'b0;
            payload_d = '0;
            a3_d      = '0;
            tnew_d    = '0;
        end
    end

    // Saturating performance counters. Each counter holds at max on its own.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall_evt && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (bubble_evt && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    // State registers. Reset is synchronous and overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            payload_q    <= '0;
            a3_q         <= '0;
            tnew_q       <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            payload_q    <= payload_d;
            a3_q         <= a3_d;
            tnew_q       <= tnew_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_payload = payload_q;
    assign out_a3      = a3_q;
    // The output presents Tnew for the next stage. It is the stored value
    // minus one, floored at zero so that it never wraps.
    assign out_tnew    = (tnew_q == '0) ? '0 : (tnew_q - TNEW_W'(1));
    assign fwd_hit     = valid_q & (a3_q != '0) & (out_tnew == '0);
    assign stall_cnt   = stall_cnt_q;
    assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg. Two instances share the same stimulus:
// inst 0 uses AGE_ON_STALL=0 with 3-bit counters, and inst 1 uses
// AGE_ON_STALL=1 with 16-bit counters. Each instance is compared every cycle
// against a behavioural model of the slot.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [95:0] in_payload;
    logic [4:0]  in_a3;
    logic [1:0]  in_tnew;
    logic        stall;
    logic        flush;

    logic        v0, v1, f0, f1;
    logic [95:0] p0, p1;
    logic [4:0]  a0, a1;
    logic [1:0]  t0, t1;
    logic [2:0]  s0, b0;
    logic [15:0] s1, b1;

    int n_checks = 0;
    int n_errors = 0;

    // Model state per instance.
    bit          mv[2];
    logic [95:0] mp[2];
    int          ma3[2];
    int          mt[2];
    int          ms[2];
    int          mb[2];
    int          cmax[2] = '{7, 65535};
    bit          age[2]  = '{1'b0, 1'b1};

    always #5 clk = ~clk;

    pipe_stage_reg #(.PAYLOAD_W(96), .REG_AW(5), .TNEW_W(2), .AGE_ON_STALL(0), .CNT_W(3)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_payload(in_payload),
        .in_a3(in_a3), .in_tnew(in_tnew), .stall(stall), .flush(flush),
        .out_valid(v0), .out_payload(p0), .out_a3(a0), .out_tnew(t0),
        .fwd_hit(f0), .stall_cnt(s0), .bubble_cnt(b0)
    );

    pipe_stage_reg #(.PAYLOAD_W(96), .REG_AW(5), .TNEW_W(2), .AGE_ON_STALL(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_payload(in_payload),
        .in_a3(in_a3), .in_tnew(in_tnew), .stall(stall), .flush(flush),
        .out_valid(v1), .out_payload(p1), .out_a3(a1), .out_tnew(t1),
        .fwd_hit(f1), .stall_cnt(s1), .bubble_cnt(b1)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat_inc(input int x, input int mx);
        return (x < mx) ? x + 1 : x;
    endfunction

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                mv[i] = 1'b0; mp[i] = '0; ma3[i] = 0; mt[i] = 0; ms[i] = 0; mb[i] = 0;
            end else if (flush) begin
                mv[i] = 1'b0; mp[i] = '0; ma3[i] = 0; mt[i] = 0;
                mb[i] = sat_inc(mb[i], cmax[i]);
            end else if (stall) begin
                ms[i] = sat_inc(ms[i], cmax[i]);
                if (age[i] && mt[i] > 0) mt[i] = mt[i] - 1;
            end else if (in_valid) begin
                mv[i] = 1'b1; mp[i] = in_payload; ma3[i] = int'(in_a3); mt[i] = int'(in_tnew);
            end else begin
                mv[i] = 1'b0; mp[i] = '0; ma3[i] = 0; mt[i] = 0;
                mb[i] = sat_inc(mb[i], cmax[i]);
            end
        end
    endtask

    task automatic check_inst(input int i);
        logic        ov, of;
        logic [95:0] op;
        int          oa, ot, sc, bc, et;
        bit          ef;
        if (i == 0) begin
            ov = v0; of = f0; op = p0; oa = int'(a0); ot = int'(t0); sc = int'(s0); bc = int'(b0);
        end else begin
            ov = v1; of = f1; op = p1; oa = int'(a1); ot = int'(t1); sc = int'(s1); bc = int'(b1);
        end
        et = (mt[i] > 0) ? mt[i] - 1 : 0;
        ef = mv[i] && (ma3[i] != 0) && (et == 0);
        chk($sformatf("valid%0d", i),   128'(ov), 128'(mv[i]));
        chk($sformatf("payload%0d", i), 128'(op), 128'(mp[i]));
        chk($sformatf("a3_%0d", i),     128'(oa), 128'(ma3[i]));
        chk($sformatf("tnew%0d", i),    128'(ot), 128'(et));
        chk($sformatf("fwd%0d", i),     128'(of), 128'(ef));
        chk($sformatf("stallcnt%0d", i),  128'(sc), 128'(ms[i]));
        chk($sformatf("bubblecnt%0d", i), 128'(bc), 128'(mb[i]));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_inst(0);
        check_inst(1);
    endtask

    task automatic drive(input bit r, input bit f, input bit s, input bit v,
                         input int a3, input int t, input logic [95:0] p);
        reset = r; flush = f; stall = s; in_valid = v;
        in_a3 = 5'(a3); in_tnew = 2'(t); in_payload = p;
        step();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        in_a3 = '0; in_tnew = '0; in_payload = '0;
        for (int i = 0; i < 2; i++) begin
            mv[i] = 1'b0; mp[i] = '0; ma3[i] = 0; mt[i] = 0; ms[i] = 0; mb[i] = 0;
        end

        // Reset, then a first advance.
        drive(1, 0, 0, 0, 0, 0, '0);
        drive(1, 0, 0, 0, 0, 0, '0);
        chk("rst_valid", 128'(v0), 128'(0));
        chk("rst_bcnt", 128'(b1), 128'(0));
        drive(0, 0, 0, 1, 8, 2, 96'hA5);
        chk("p1_valid", 128'(v0), 128'(1));
        chk("p1_a3", 128'(a0), 128'(8));
        chk("p1_tnew", 128'(t0), 128'(1));
        chk("p1_fwd", 128'(f0), 128'(0));

        // Tnew floor and the forwarding qualifier.
        drive(0, 0, 0, 1, 3, 0, 96'h11);
        chk("p2_fwd_t0", 128'(f0), 128'(1));
        drive(0, 0, 0, 1, 3, 1, 96'h12);
        chk("p2_tnew_t1", 128'(t0), 128'(0));
        chk("p2_fwd_t1", 128'(f0), 128'(1));
        drive(0, 0, 0, 1, 0, 0, 96'h13);
        chk("p2_fwd_a0", 128'(f0), 128'(0));

        // Stall hold vs ageing.
        drive(1, 0, 0, 0, 0, 0, '0);
        drive(0, 0, 0, 1, 4, 3, 96'hBEEF);
        for (int k = 0; k < 3; k++) drive(0, 0, 1, 0, 0, 0, '0);
        chk("p3_hold_tnew", 128'(t0), 128'(2));
        chk("p3_hold_pl", 128'(p0), 128'(96'hBEEF));
        chk("p3_scnt", 128'(s0), 128'(3));
        chk("p3_age_tnew", 128'(t1), 128'(0));
        chk("p3_age_fwd", 128'(f1), 128'(1));

        // Flush wins over stall.
        drive(0, 1, 1, 1, 9, 1, 96'h77);
        chk("p4_valid", 128'(v0), 128'(0));
        chk("p4_scnt", 128'(s0), 128'(3));
        chk("p4_bcnt", 128'(b0), 128'(1));

        // Upstream bubble carries a3=0.
        drive(0, 0, 0, 1, 6, 0, 96'h5);
        drive(0, 0, 0, 0, 31, 0, 96'hFFFF);
        chk("p5_a3", 128'(a0), 128'(0));
        chk("p5_bcnt", 128'(b0), 128'(2));

        // Counter saturation, then reset mid-stall.
        for (int k = 0; k < 10; k++) drive(0, 0, 1, 1, 2, 2, 96'h9);
        chk("p6_scnt_sat", 128'(s0), 128'(7));
        chk("p6_scnt_wide", 128'(s1), 128'(13));
        drive(1, 0, 1, 1, 2, 2, 96'h9);
        chk("p6_rst_scnt", 128'(s0), 128'(0));
        chk("p6_rst_bcnt", 128'(b0), 128'(0));

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 3)),
                  {$urandom, $urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the 5-stage MIPS core. It replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block.
- Adds a valid bit, stall (hold), flush (bubble insertion) and optional Tnew ageing while stalled.
- Produces a forwarding-qualified hit flag.
- Keeps saturating stall and bubble performance counters for hazard-unit debug.

Parameters:
PAYLOAD_W, 96, width of packed payload (e.g. {Instr, PC4, WD})
REG_AW, 5, destination register address width (A3)
TNEW_W, 2, width of Tnew field
AGE_ON_STALL, 0, 1 = stored Tnew decrements (saturating) on each stall cycle; 0 = Tnew held during stall
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all state
in_valid  in  1  upstream stage holds a real instruction
in_payload  in  PAYLOAD_W  upstream payload bundle
in_a3  in  REG_AW  upstream destination register (0 = no write)
in_tnew  in  TNEW_W  upstream Tnew (cycles until result available)
stall  in  1  hold current contents this cycle
flush  in  1  replace contents with a bubble this cycle
out_valid  out  1  registered valid
out_payload  out  PAYLOAD_W  registered payload
out_a3  out  REG_AW  registered A3
out_tnew  out  TNEW_W  stored Tnew minus 1, saturating at 0 (combinational from stored value)
fwd_hit  out  1  out_valid & (out_a3 != 0) & (out_tnew == 0)
stall_cnt  out  CNT_W  number of cycles with stall applied (saturating)
bubble_cnt  out  CNT_W  number of bubbles entered via flush or in_valid=0 (saturating)

Behaviour:
- Reset (sync, active-high, clk rising edge): valid, payload, a3, stored tnew, stall_cnt, bubble_cnt all 0. Consequently out_tnew=0, fwd_hit=0. Reset overrides every other input.
- Per-edge priority when reset=0: flush > stall > advance.
- Flush: valid=0, payload=0, a3=0, tnew=0; bubble_cnt+1. Flush with stall asserted still flushes; stall_cnt is not incremented in that cycle.
- Stall (flush=0): valid, payload and a3 held.
  - AGE_ON_STALL=0: stored tnew held.
  - AGE_ON_STALL=1: stored tnew := (tnew==0) ? 0 : tnew-1.
  - stall_cnt+1, regardless of valid.
- Advance (flush=0, stall=0):
  - in_valid=1: load in_payload, in_a3, in_tnew; valid=1.
  - in_valid=0: load a bubble (all fields 0, valid=0); bubble_cnt+1.
- Latency: one cycle from input to output on advance. No combinational path from in_* to out_*.
- out_tnew = (stored==0) ? 0 : stored-1, evaluated in TNEW_W bits. Never wraps below 0.
- Bubbles always carry a3=0, so out_a3 is 0 whenever out_valid=0. fwd_hit is therefore never set for a bubble.
- Counters saturate at 2^CNT_W-1 and do not wrap. The counter of the active event holds at max; the other counter keeps counting.
- No internal reset-pending state. Reset asserted mid-stall or mid-flush produces the reset values on the next edge. Release takes effect on the first edge with reset=0.

Test Plan:
1. Reset then advance: reset 2 cycles; verify all outputs 0. Then in_valid=1, in_a3=5'd8, in_tnew=2, in_payload=96'hA5; next edge → out_valid=1, out_a3=8, out_tnew=1, fwd_hit=0.
2. Tnew floor: load in_tnew=0 with in_a3=3 → out_tnew=0, fwd_hit=1. Load in_tnew=1 → out_tnew=0, fwd_hit=1. Load a3=0, tnew=0 → fwd_hit=0.
3. Stall hold/ageing: load tnew=3, then stall 3 cycles.
   - AGE_ON_STALL=0: out_tnew stays 2 and payload is unchanged; stall_cnt=3.
   - AGE_ON_STALL=1: out_tnew goes 1, 0, 0; fwd_hit rises once out_tnew=0 with a3≠0.
4. Flush priority: valid entry held under stall; assert flush+stall together → next edge out_valid=0, out_a3=0, payload=0, bubble_cnt+1, stall_cnt unchanged.
5. Bubble from upstream: advance with in_valid=0 and in_a3=5'd31 → out_valid=0, out_a3=0, fwd_hit=0, bubble_cnt+1.
6. Counter saturation and mid-op reset: with CNT_W=3, stall 10 cycles → stall_cnt=7 and holds. Then assert reset during the stall → both counters and all outputs 0 on the next edge.
